// File: rtl/imem_responder.sv
// imem_responder: instruction-memory responder with fixed LATENCY and a
// handshake-held response (IDLE/WAIT/RESP). Ports are listed below.
//
// Ports:
//   clk                  sole clock, rising edge
//   rst                  asynchronous active-low reset
//   Imem_raddr[31:0]     fetch byte address, captured in IDLE when ready=1
//   io_Imem_rdata_ready  request strobe in IDLE, accept strobe in RESP
//   io_Imem_rdata_valid  response present on io_Imem_rdata_bits
//   io_Imem_rdata_bits   fetched word (0 for an illegal address)
//   fetch_err            response is for an illegal address
//   prog_wen/prog_addr/prog_wdata  synchronous word write load port
//   trap_hit             ebreak delivered on this handshake
//
// Optional feature: define IMEM_EBREAK_DETECT_EN to build the ebreak
// compare behind trap_hit. Without it, trap_hit is tied to 0.
// DEPTH_WORDS must be a power of two, at least 2.
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h80000000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Imem_raddr,
  input  logic        io_Imem_rdata_ready,
  output logic        io_Imem_rdata_valid,
  output logic [31:0] io_Imem_rdata_bits,
  output logic        fetch_err,
  input  logic        prog_wen,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_wdata,
  output logic        trap_hit
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
  localparam logic [32:0] BASE33 = {1'b0, BASE_ADDR};
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [31:0] mem [DEPTH_WORDS];

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] bits_q, bits_d;
  logic        err_q, err_d;

  // 33-bit offsets: bit 32 set means the address is below BASE_ADDR,
  // so no address ever wraps onto a legal word.
  logic [32:0]   r_off, w_off;
  logic          r_ok, w_ok;
  logic [AW-1:0] r_idx, w_idx;

  assign r_off = {1'b0, addr_q} - BASE33;
  assign r_ok  = !r_off[32] && (r_off < SPAN)
              && (addr_q[1:0] == 2'b00);
  assign r_idx = r_off[AW+1:2];

  assign w_off = {1'b0, prog_addr} - BASE33;
  assign w_ok  = !w_off[32] && (w_off < SPAN)
              && (prog_addr[1:0] == 2'b00);
  assign w_idx = w_off[AW+1:2];

  // Contents survive reset; the read below samples the pre-write
  // value when both hit the same word on one edge.
  always_ff @(posedge clk) begin
    if (prog_wen && w_ok) mem[w_idx] <= prog_wdata;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    bits_d  = bits_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (io_Imem_rdata_ready) begin
          addr_d  = Imem_raddr;
          cnt_d   = LAT_M1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          bits_d  = r_ok ? mem[r_idx] : 32'h0;
          err_d   = !r_ok;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (io_Imem_rdata_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      bits_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      bits_q  <= bits_d;
      err_q   <= err_d;
    end
  end

  assign io_Imem_rdata_valid = (state_q == S_RESP);
  assign io_Imem_rdata_bits  = bits_q;
  assign fetch_err           = err_q;

`ifdef IMEM_EBREAK_DETECT_EN
  localparam logic [31:0] EBREAK = 32'h00100073;
  assign trap_hit = io_Imem_rdata_valid && io_Imem_rdata_ready
                 && !err_q && (bits_q == EBREAK);
`else
  assign trap_hit = 1'b0;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: randomized and directed bench for imem_responder
// against a word-array reference model of the load port and fetch rules.
module tb_imem_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h80000000;
  localparam int          LAT   = 2;
  localparam logic [31:0] EBRK  = 32'h00100073;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] raddr = '0;
  logic        rdy = 1'b0;
  logic        valid;
  logic [31:0] bits;
  logic        err;
  logic        wen = 1'b0;
  logic [31:0] waddr = '0;
  logic [31:0] wdata = '0;
  logic        trap;

  int checks = 0;
  int passes = 0;
  int hs_cnt = 0;

  logic [31:0] mdl [DEPTH];
  bit          mvld [DEPTH];

  imem_responder #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR(BASE),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .Imem_raddr(raddr),
    .io_Imem_rdata_ready(rdy),
    .io_Imem_rdata_valid(valid),
    .io_Imem_rdata_bits(bits),
    .fetch_err(err),
    .prog_wen(wen),
    .prog_addr(waddr),
    .prog_wdata(wdata),
    .trap_hit(trap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (valid && rdy) hs_cnt <= hs_cnt + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic bit m_legal(input logic [31:0] a);
    longint x;
    longint lo;
    x  = longint'(a);
    lo = longint'(BASE);
    return (x >= lo) && (x < lo + 4 * DEPTH) && (x % 4 == 0);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  task automatic prog_write(input logic [31:0] a, input logic [31:0] d);
    wen = 1'b1; waddr = a; wdata = d;
    @(posedge clk); #1;
    wen = 1'b0;
    if (m_legal(a)) begin
      mdl[m_idx(a)]  = d;
      mvld[m_idx(a)] = 1'b1;
    end
  endtask

  // Stimulus only: issue one fetch with ready held, report what was seen.
  task automatic do_fetch(input logic [31:0] a, output logic [31:0] b,
                          output logic e, output int lat,
                          output logic tr, output logic v_after,
                          output logic tr_after);
    int cyc;
    raddr = a; rdy = 1'b1;
    @(posedge clk); #1;
    raddr = $urandom;
    cyc = 0;
    while (!valid && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    lat = valid ? cyc : -1;
    b = bits; e = err; tr = trap;
    @(posedge clk); #1;
    v_after = valid; tr_after = trap;
    rdy = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (valid !== 1'b0 || bits !== 32'h0 || err !== 1'b0 || trap !== 1'b0)
      $display("FAIL reset_outputs: got v=%b b=%h e=%b t=%b want 0", valid, bits, err, trap);
    else passes++;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (valid !== 1'b0) $display("FAIL reset_held: valid=%b want 0", valid);
    else passes++;
    rst = 1'b1;
  endtask

  task automatic test_basic;
    logic [31:0] b; logic e, tr, va, ta; int lat;
    prog_write(BASE, 32'h00100093);
    do_fetch(BASE, b, e, lat, tr, va, ta);
    checks++;
    if (lat !== LAT) $display("FAIL basic_latency: got %0d want %0d", lat, LAT);
    else passes++;
    checks++;
    if (b !== 32'h00100093) $display("FAIL basic_bits: got %h want 00100093", b);
    else passes++;
    checks++;
    if (e !== 1'b0) $display("FAIL basic_err: got %b want 0", e);
    else passes++;
    checks++;
    if (va !== 1'b0) $display("FAIL basic_valid_drop: got %b want 0", va);
    else passes++;
    checks++;
    if (tr !== 1'b0) $display("FAIL basic_trap: got %b want 0", tr);
    else passes++;
  endtask

  task automatic test_ready_drop;
    logic [31:0] b0; int cyc, hs0, extra; bit stable;
    hs0 = hs_cnt;
    raddr = BASE; rdy = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b0; raddr = $urandom;
    cyc = 0;
    while (!valid && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== LAT) $display("FAIL drop_latency: got %0d want %0d", cyc, LAT);
    else passes++;
    b0 = bits;
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (!valid || bits !== b0) stable = 1'b0;
    end
    checks++;
    if (!stable) $display("FAIL drop_hold: v=%b b=%h want 1 %h", valid, bits, b0);
    else passes++;
    checks++;
    if (b0 !== mdl[0]) $display("FAIL drop_bits: got %h want %h", b0, mdl[0]);
    else passes++;
    rdy = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b0;
    checks++;
    if (valid !== 1'b0) $display("FAIL drop_release: valid=%b want 0", valid);
    else passes++;
    extra = 0;
    repeat (LAT + 3) begin
      @(posedge clk); #1;
      if (valid) extra++;
    end
    checks++;
    if (hs_cnt - hs0 !== 1 || extra !== 0)
      $display("FAIL drop_single_hs: got hs=%0d extra=%0d want 1 0", hs_cnt - hs0, extra);
    else passes++;
  endtask

  task automatic test_illegal;
    logic [31:0] bad [3];
    logic [31:0] b; logic e, tr, va, ta; int lat;
    bad[0] = 32'h7FFFFFFC;
    bad[1] = 32'h80000002;
    bad[2] = BASE + 32'(4 * DEPTH);
    foreach (bad[i]) begin
      do_fetch(bad[i], b, e, lat, tr, va, ta);
      checks++;
      if (b !== 32'h0 || e !== 1'b1 || lat !== LAT)
        $display("FAIL illegal_%0d: got b=%h e=%b lat=%0d want 0 1 %0d", i, b, e, lat, LAT);
      else passes++;
    end
    prog_write(BASE, 32'hA5A50001);
    prog_write(BASE + 32'(4 * DEPTH), 32'hBADBAD00);
    prog_write(32'h80000001, 32'hBADBAD01);
    prog_write(32'h7FFFFFFC, 32'hBADBAD02);
    do_fetch(BASE, b, e, lat, tr, va, ta);
    checks++;
    if (b !== 32'hA5A50001 || e !== 1'b0)
      $display("FAIL illegal_write_ignored: got %h e=%b want a5a50001 0", b, e);
    else passes++;
  endtask

  task automatic test_rbw;
    logic [31:0] a, oldw, b; logic e, tr, va, ta; int lat;
    a = BASE + 32'd8;
    prog_write(a, 32'h11112222);
    oldw = mdl[m_idx(a)];
    raddr = a; rdy = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b0;
    repeat (LAT - 1) begin
      @(posedge clk); #1;
    end
    wen = 1'b1; waddr = a; wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    wen = 1'b0;
    mdl[m_idx(a)] = 32'hDEADBEEF;
    checks++;
    if (valid !== 1'b1 || bits !== oldw)
      $display("FAIL rbw_old: got v=%b b=%h want 1 %h", valid, bits, oldw);
    else passes++;
    wen = 1'b1; waddr = a; wdata = 32'h0BADF00D;
    @(posedge clk); #1;
    wen = 1'b0;
    mdl[m_idx(a)] = 32'h0BADF00D;
    checks++;
    if (valid !== 1'b1 || bits !== oldw)
      $display("FAIL resp_write_hold: got v=%b b=%h want 1 %h", valid, bits, oldw);
    else passes++;
    rdy = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b0;
    prog_write(a, 32'hDEADBEEF);
    do_fetch(a, b, e, lat, tr, va, ta);
    checks++;
    if (b !== 32'hDEADBEEF || e !== 1'b0)
      $display("FAIL rbw_new: got %h e=%b want deadbeef 0", b, e);
    else passes++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] b; logic e, tr, va, ta; int lat, cyc, stray;
    raddr = BASE; rdy = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0 || bits !== 32'h0 || err !== 1'b0)
      $display("FAIL rst_wait: got v=%b b=%h e=%b want 0 0 0", valid, bits, err);
    else passes++;
    @(posedge clk); #1;
    rst = 1'b1;
    stray = 0;
    repeat (LAT + 3) begin
      @(posedge clk); #1;
      if (valid) stray++;
    end
    checks++;
    if (stray !== 0) $display("FAIL rst_wait_discard: got %0d valid cycles want 0", stray);
    else passes++;
    raddr = 32'h80000002; rdy = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b0;
    cyc = 0;
    while (!valid && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (valid !== 1'b1 || err !== 1'b1)
      $display("FAIL rst_resp_setup: got v=%b e=%b want 1 1", valid, err);
    else passes++;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0 || err !== 1'b0 || bits !== 32'h0)
      $display("FAIL rst_resp: got v=%b b=%h e=%b want 0 0 0", valid, bits, err);
    else passes++;
    @(posedge clk); #1;
    rst = 1'b1;
    do_fetch(BASE, b, e, lat, tr, va, ta);
    checks++;
    if (lat !== LAT || b !== mdl[0] || e !== 1'b0)
      $display("FAIL rst_recover: got lat=%0d b=%h e=%b want %0d %h 0", lat, b, e, LAT, mdl[0]);
    else passes++;
  endtask

  task automatic test_random;
    logic [31:0] a, b, eb; logic e, tr, va, ta, lg; int lat, k;
    for (int i = 0; i < 32; i++) prog_write(BASE + 32'(4 * i), $urandom);
    for (int it = 0; it < 40; it++) begin
      k = $urandom_range(0, 5);
      if (k <= 2) a = BASE + 32'(4 * $urandom_range(0, 31));
      else if (k == 3) a = BASE - 32'(4 * $urandom_range(1, 64));
      else if (k == 4) a = BASE + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(1, 3));
      else a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 64));
      if ($urandom_range(0, 3) == 0)
        prog_write(BASE + 32'(4 * $urandom_range(0, 31)), $urandom);
      lg = m_legal(a);
      eb = lg ? mdl[m_idx(a)] : 32'h0;
      do_fetch(a, b, e, lat, tr, va, ta);
      checks++;
      if (lat !== LAT || e !== !lg || b !== eb || va !== 1'b0)
        $display("FAIL rand_%0d a=%h: got lat=%0d b=%h e=%b v=%b want %0d %h %b 0",
                 it, a, lat, b, e, va, LAT, eb, !lg);
      else passes++;
    end
  endtask

  task automatic test_trap;
    logic [31:0] a, b; logic e, tr, va, ta, exp_t; int lat, cyc;
`ifdef IMEM_EBREAK_DETECT_EN
    exp_t = 1'b1;
`else
    exp_t = 1'b0;
`endif
    a = BASE + 32'd16;
    prog_write(a, EBRK);
    do_fetch(a, b, e, lat, tr, va, ta);
    checks++;
    if (b !== EBRK || tr !== exp_t)
      $display("FAIL trap_hit: got b=%h t=%b want %h %b", b, tr, EBRK, exp_t);
    else passes++;
    checks++;
    if (ta !== 1'b0) $display("FAIL trap_after: got %b want 0", ta);
    else passes++;
    raddr = a; rdy = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b0;
    cyc = 0;
    while (!valid && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (valid !== 1'b1 || trap !== 1'b0)
      $display("FAIL trap_stall: got v=%b t=%b want 1 0", valid, trap);
    else passes++;
    rdy = 1'b1;
    #1;
    checks++;
    if (trap !== exp_t) $display("FAIL trap_late_hs: got %b want %b", trap, exp_t);
    else passes++;
    @(posedge clk); #1;
    rdy = 1'b0;
  endtask

  initial begin
    test_reset;
    @(posedge clk); #1;
    test_basic;
    test_ready_drop;
    test_illegal;
    test_rbw;
    test_reset_mid;
    test_random;
    test_trap;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, SHALL set the instruction store size in 32-bit words (power of two).
REQ-002 Parameter BASE_ADDR, default 32'h80000000, SHALL set the byte address of word 0.
REQ-003 Parameter LATENCY, default 2, range 1..15, SHALL set the cycles from request capture to response valid.
REQ-004 clk  input  1  SHALL be the sole clock; all state rises on posedge clk.
REQ-005 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 Imem_raddr  input  32  SHALL be the fetch byte address from the core.
REQ-007 io_Imem_rdata_ready  input  1  SHALL be the core's request / accept strobe.
REQ-008 io_Imem_rdata_valid  output  1  SHALL indicate io_Imem_rdata_bits holds a response.
REQ-009 io_Imem_rdata_bits  output  32  SHALL carry the fetched instruction word.
REQ-010 fetch_err  output  1  SHALL flag that the current response is for an illegal address.
REQ-011 prog_wen / prog_addr[31:0] / prog_wdata[31:0]  inputs  SHALL form a synchronous word-write load port.
REQ-012 trap_hit  output  1  SHALL pulse on delivery of an ebreak (see Configuration).

Function
REQ-013 The FSM SHALL have states IDLE, WAIT, RESP.
REQ-014 In IDLE with ready=1, it SHALL capture Imem_raddr, load a down-counter with LATENCY-1, and go to WAIT next cycle.
REQ-015 In WAIT, the counter SHALL decrement each cycle; at 0 the block SHALL read the array, register the word, and enter RESP.
REQ-016 Result: valid SHALL rise exactly LATENCY cycles after the capturing edge.
REQ-017 In RESP, valid=1; bits and fetch_err SHALL stay stable until valid&ready is sampled high.
REQ-018 On handshake, the block SHALL return to IDLE; valid SHALL be 0 for at least one cycle before the next response (no back-to-back responses).
REQ-019 Imem_raddr changes after capture SHALL NOT affect the outstanding response.
REQ-020 ready falling during WAIT SHALL NOT cancel the fetch; the response SHALL wait in RESP.
REQ-021 Word index SHALL be (addr-BASE_ADDR)>>2, modulo-free: an address below BASE_ADDR, at or above BASE_ADDR+4*DEPTH_WORDS, or with addr[1:0]!=0 SHALL be illegal.
REQ-022 For an illegal address, the block SHALL respond bits=32'h00000000 and fetch_err=1 at normal latency.
REQ-023 prog_wen=1 with a legal prog_addr SHALL write prog_wdata at the posedge; an illegal prog_addr write SHALL be ignored.
REQ-024 A write to the same word in the read cycle SHALL return the old data (read-before-write); writes during RESP SHALL NOT alter the held bits.
REQ-025 Array contents SHALL be undefined after power-up and SHALL be unaffected by reset.

Reset
REQ-026 While rst=0, the FSM SHALL be IDLE and counter=0, with outputs valid=0, bits=0, fetch_err=0, trap_hit=0, asserted asynchronously.
REQ-027 Reset during WAIT or RESP SHALL drop valid immediately and discard the outstanding fetch.
REQ-028 The first request after rst rises SHALL be accepted on the first posedge sampling ready=1.

Configuration
REQ-029 With macro IMEM_EBREAK_DETECT_EN defined, trap_hit SHALL be 1 for exactly the handshake cycle when bits==32'h00100073 and fetch_err=0.
REQ-030 Without IMEM_EBREAK_DETECT_EN, trap_hit SHALL be tied to 0 and no compare logic SHALL exist.

Verification
REQ-031 Load 32'h00100093 at 0x80000000, LATENCY=2, ready=1 held -> valid rises 2 cycles after capture, bits=32'h00100093, fetch_err=0, valid low the next cycle.
REQ-032 Request 0x80000000, drop ready during WAIT, raise it 5 cycles later -> valid held with stable bits; a single handshake occurs.
REQ-033 Fetch at 0x7FFFFFFC, 0x80000002, and 0x80001000 (DEPTH 1024) -> each returns bits=0 and fetch_err=1.
REQ-034 Write 32'hDEADBEEF to the word being read in the read cycle -> old word returned; a following fetch returns 32'hDEADBEEF.
REQ-035 Assert rst=0 mid-WAIT and mid-RESP -> valid=0 immediately; after release, a new fetch completes normally.
REQ-036 With IMEM_EBREAK_DETECT_EN, fetch a stored 32'h00100073 -> trap_hit=1 for the single handshake cycle only; 0 when the macro is undefined.
